// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM states, instruction
// field bit positions, opcode/func constants and the default reset PC.
// No logic; imported by fetch_unit and anything that decodes fields.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_HOLD   = 3'd2,
      ST_DROP   = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_t;

   // Instruction field bit positions
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNC_MSB   = 5;
   localparam int FUNC_LSB   = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int JIDX_MSB   = 25;
   localparam int JIDX_LSB   = 0;

   localparam logic [5:0]  OP_RTYPE         = 6'h00;
   localparam logic [5:0]  FUNC_SYSCALL     = 6'h0C;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, registered word to decode.
// Latency: response accepted in FETCH -> inst_valid next cycle; 2 cycles/instr at zero-wait.
// Backpressure: holds inst and fields while inst_valid && !inst_ready; no new request until handshake.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   imem_req/addr/rvalid/rdata   instruction memory request/response
//   inst_valid/inst_ready        handshake to decode
//   inst, inst_pc, pc_plus4      registered word, its PC, PC+4
//   opcode..jidx                 fields sliced from inst
//   redirect/redirect_pc         branch/jump redirect (target word-aligned here)
//   halt, fetch_halted           halt on accepted instruction; sticky until reset
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_plus4,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] jidx,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_halted
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;        // next PC to fetch
   logic [31:0]  addr_q;      // address of the request on the bus
   logic         req_q;
   logic         vld_q;
   logic         halted_q;
   logic [31:0]  inst_q;
   logic [31:0]  inst_pc_q;

   logic [31:0]  redir_pc_d;  // word-aligned redirect target
   logic [31:0]  drop_pc_d;   // target to issue when the dropped response lands
   logic         unused_rpc_lsbs;

   assign redir_pc_d      = {redirect_pc[31:2], 2'b00};
   assign drop_pc_d       = redirect ? redir_pc_d : pc_q;
   assign unused_rpc_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         req_q     <= 1'b0;
         vld_q     <= 1'b0;
         halted_q  <= 1'b0;
         inst_q    <= 32'h0;
         inst_pc_q <= 32'h0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            ST_FETCH: begin
               if (redirect) begin
                  pc_q <= redir_pc_d;
                  if (imem_rvalid) begin
                     // Response already here: drop it and re-issue at the target now.
                     addr_q <= redir_pc_d;
                  end else begin
                     // Request cannot be withdrawn; wait for it in DROP.
                     state_q <= ST_DROP;
                  end
               end else if (imem_rvalid) begin
                  inst_q    <= imem_rdata;
                  inst_pc_q <= pc_q;
                  pc_q      <= pc_q + 32'd4;
                  req_q     <= 1'b0;
                  vld_q     <= 1'b1;
                  state_q   <= ST_HOLD;
               end
            end
            ST_DROP: begin
               if (imem_rvalid) begin
                  // Stale response discarded; a redirect in the same cycle still wins.
                  pc_q    <= drop_pc_d;
                  addr_q  <= drop_pc_d;
                  state_q <= ST_FETCH;
               end else if (redirect) begin
                  pc_q <= redir_pc_d;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pc_q    <= redir_pc_d;
                  addr_q  <= redir_pc_d;
                  req_q   <= 1'b1;
                  vld_q   <= 1'b0;
                  state_q <= ST_FETCH;
               end else if (inst_ready) begin
                  vld_q <= 1'b0;
                  if (halt) begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALTED;
                  end else begin
                     req_q   <= 1'b1;
                     addr_q  <= pc_q;
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_HALTED: begin
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = addr_q;
   assign inst_valid   = vld_q;
   assign fetch_halted = halted_q;
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign pc_plus4     = inst_pc_q + 32'd4;

   assign opcode = inst_q[OPCODE_MSB:OPCODE_LSB];
   assign rs     = inst_q[RS_MSB:RS_LSB];
   assign rt     = inst_q[RT_MSB:RT_LSB];
   assign rd     = inst_q[RD_MSB:RD_LSB];
   assign shamt  = inst_q[SHAMT_MSB:SHAMT_LSB];
   assign func   = inst_q[FUNC_MSB:FUNC_LSB];
   assign imm16  = inst_q[IMM_MSB:IMM_LSB];
   assign jidx   = inst_q[JIDX_MSB:JIDX_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, field-decode table, and a
// randomized run against a transaction-level model of the fetched stream.
module tb_fetch_unit;
   import mips_pkg::*;

   logic        clk, reset;
   logic        imem_req, imem_rvalid, inst_valid, inst_ready;
   logic        redirect, halt, fetch_halted;
   logic [31:0] imem_addr, imem_rdata, inst, inst_pc, pc_plus4, redirect_pc;
   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] jidx;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
      .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .imm16(imm16), .jidx(jidx),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .fetch_halted(fetch_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] word;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] j;
   } vec_t;

   vec_t tbl [6];

   // random-run state
   logic [31:0] exp_pc, exp_w, prev_addr, prev_inst, prev_ipc, rpc;
   logic        rv, rdy, rdr, prev_pending, prev_stall;
   int          wait_cnt, lat, deliveries;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic r,
                        input logic rd_en, input logic [31:0] rpc_in, input logic h);
      imem_rvalid = v;
      imem_rdata  = d;
      inst_ready  = r;
      redirect    = rd_en;
      redirect_pc = rpc_in;
      halt        = h;
   endtask

   // Memory contents for the random run: a fixed scramble of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h2008_0005, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h05, 16'h0005, 26'h008_0005};
      tbl[1] = '{32'h012A_4020, OP_RTYPE, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h12A_4020};
      tbl[2] = '{32'h0000_000C, OP_RTYPE, 5'd0, 5'd0, 5'd0, 5'd0, FUNC_SYSCALL, 16'h000C, 26'h000_000C};
      tbl[3] = '{32'h0810_0004, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h010_0004};
      tbl[4] = '{32'hFFFF_FFFF, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF};
      tbl[5] = '{32'h0004_2080, OP_RTYPE, 5'd0, 5'd4, 5'd4, 5'd2, 6'h00, 16'h2080, 26'h004_2080};

      // ---- reset state ----
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); tick();
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_pc_plus4", pc_plus4, 4);
      check("rst_halted", fetch_halted, 0);
      check("rst_opcode", opcode, 0);
      reset = 1'b0;
      check("c1_idle_req", imem_req, 0);

      // ---- zero-wait first fetch: valid on cycle 3 ----
      tick();
      check("c2_req", imem_req, 1);
      check("c2_addr", imem_addr, 0);
      check("c2_valid", inst_valid, 0);
      drive(1'b1, 32'h2008_0005, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("c3_valid", inst_valid, 1);
      check("c3_opcode", opcode, 6'h08);
      check("c3_rt", rt, 8);
      check("c3_imm16", imm16, 5);
      check("c3_inst_pc", inst_pc, 0);
      check("c3_req", imem_req, 0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("next_req", imem_req, 1);
      check("next_addr", imem_addr, 4);
      check("next_valid", inst_valid, 0);

      // ---- 3-cycle latency, then 4 stalled cycles (halt ignored without handshake) ----
      for (int c = 0; c < 3; c++) begin
         check("lat_req", imem_req, 1);
         check("lat_addr", imem_addr, 4);
         check("lat_valid", inst_valid, 0);
         drive(c == 2, (c == 2) ? 32'h012A_4020 : 32'hDEAD_0000, 1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         check("stall_valid", inst_valid, 1);
         check("stall_inst", inst, 32'h012A_4020);
         check("stall_inst_pc", inst_pc, 4);
         check("stall_pc_plus4", pc_plus4, 8);
         check("stall_no_req", imem_req, 0);
         drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
      check("stall_still_valid", inst_valid, 1);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("after_stall_req", imem_req, 1);
      check("after_stall_addr", imem_addr, 8);
      check("after_stall_halted", fetch_halted, 0);

      // ---- redirect in FETCH before the response ----
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
      tick();
      check("drop_req", imem_req, 1);
      check("drop_addr_old", imem_addr, 8);
      check("drop_valid", inst_valid, 0);
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("redir_req", imem_req, 1);
      check("redir_addr", imem_addr, 32'h40);
      check("redir_no_valid", inst_valid, 0);
      drive(1'b1, 32'h0810_0004, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("redir_valid", inst_valid, 1);
      check("redir_inst", inst, 32'h0810_0004);
      check("redir_inst_pc", inst_pc, 32'h40);

      // ---- redirect + ready in HOLD: redirect wins, target aligned ----
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h103, 1'b0);
      tick();
      check("hold_redir_valid", inst_valid, 0);
      check("hold_redir_req", imem_req, 1);
      check("hold_redir_addr", imem_addr, 32'h100);

      // ---- halt on syscall handshake ----
      drive(1'b1, 32'h0000_000C, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("sys_valid", inst_valid, 1);
      check("sys_func", func, FUNC_SYSCALL);
      check("sys_inst_pc", inst_pc, 32'h100);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      check("halt_flag", fetch_halted, 1);
      check("halt_valid", inst_valid, 0);
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, $urandom, 1'($urandom_range(0, 1)), (c % 5) == 0, 32'h200, 1'($urandom_range(0, 1)));
         tick();
         check("halted_no_req", imem_req, 0);
         check("halted_flag", fetch_halted, 1);
      end
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      reset = 1'b0;
      check("unhalt_flag", fetch_halted, 0);
      tick();
      check("unhalt_req", imem_req, 1);
      check("unhalt_addr", imem_addr, 0);

      // ---- rvalid + redirect in FETCH, and PC wrap ----
      drive(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      tick();
      check("wrap_req", imem_req, 1);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap_discard", inst_valid, 0);
      drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("wrap_valid", inst_valid, 1);
      check("wrap_inst", inst, 32'h2222_2222);
      check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      check("wrap_pc_plus4", pc_plus4, 0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("wrap_next_addr", imem_addr, 0);
      check("wrap_next_req", imem_req, 1);

      // ---- async reset in DROP ----
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0);
      tick();
      check("adrop_req", imem_req, 1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("async_req", imem_req, 0);
      check("async_addr", imem_addr, 0);
      check("async_valid", inst_valid, 0);
      tick();
      reset = 1'b0;
      tick();

      // ---- field decode table, zero-wait, halt high outside HOLD ----
      for (int i = 0; i < 6; i++) begin
         check("tbl_req", imem_req, 1);
         check("tbl_addr", imem_addr, 32'(i * 4));
         drive(1'b1, tbl[i].word, 1'b1, 1'b0, 32'h0, 1'b1);
         tick();
         check("tbl_valid", inst_valid, 1);
         check("tbl_inst", inst, tbl[i].word);
         check("tbl_opcode", opcode, tbl[i].op);
         check("tbl_rs", rs, tbl[i].rs);
         check("tbl_rt", rt, tbl[i].rt);
         check("tbl_rd", rd, tbl[i].rd);
         check("tbl_shamt", shamt, tbl[i].sh);
         check("tbl_func", func, tbl[i].fn);
         check("tbl_imm16", imm16, tbl[i].imm);
         check("tbl_jidx", jidx, tbl[i].j);
         check("tbl_inst_pc", inst_pc, 32'(i * 4));
         check("tbl_pc_plus4", pc_plus4, 32'(i * 4 + 4));
         drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         tick();
      end

      // ---- randomized run vs. expected instruction stream ----
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      exp_pc       = 32'h0;
      wait_cnt     = 0;
      lat          = $urandom_range(0, 3);
      prev_pending = 1'b0;
      prev_stall   = 1'b0;
      prev_addr    = 32'h0;
      prev_inst    = 32'h0;
      prev_ipc     = 32'h0;
      deliveries   = 0;
      for (int c = 0; c < 800; c++) begin
         if (prev_pending) begin
            check("rnd_req_held", imem_req, 1);
            check("rnd_addr_held", imem_addr, prev_addr);
         end
         if (prev_stall) begin
            check("rnd_stall_valid", inst_valid, 1);
            check("rnd_stall_inst", inst, prev_inst);
            check("rnd_stall_pc", inst_pc, prev_ipc);
         end
         rv  = imem_req && (wait_cnt >= lat);
         rdy = 1'($urandom_range(0, 1));
         rdr = ($urandom_range(0, 7) == 0);
         rpc = $urandom & 32'h0000_0FFF;
         drive(rv, rv ? memf(imem_addr) : $urandom, rdy, rdr, rpc, 1'b0);
         if (inst_valid && rdy && !rdr) begin
            exp_w = memf(exp_pc);
            check("rnd_inst_pc", inst_pc, exp_pc);
            check("rnd_inst", inst, exp_w);
            check("rnd_rs", rs, exp_w[25:21]);
            check("rnd_imm16", imm16, exp_w[15:0]);
            check("rnd_pc_plus4", pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end
         if (rdr) exp_pc = {rpc[31:2], 2'b00};
         prev_pending = imem_req && !rv;
         prev_addr    = imem_addr;
         prev_stall   = inst_valid && !rdy && !rdr;
         prev_inst    = inst;
         prev_ipc     = inst_pc;
         tick();
         if (rv) begin
            wait_cnt = 0;
            lat      = $urandom_range(0, 3);
         end else if (prev_pending) begin
            wait_cnt++;
         end
      end
      check("rnd_progress", deliveries >= 30, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
